// File: rtl/pipelined_magnitude_compare.sv
// ---------------------------------------------------------------------------
// pipelined_magnitude_compare
// Digit-serial LSB-first magnitude comparator; signed/unsigned, gt/eq/lt out.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipelined_magnitude_compare #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int STAGES    = (WIDTH / DIGIT < 1) ? 1 : WIDTH / DIGIT;
  localparam int DATA_BITS = DIGIT * (STAGES * (STAGES - 1) / 2);
  localparam int PIPE_BITS = (DATA_BITS > 0) ? DATA_BITS : 1;
  localparam int SM_BITS   = (STAGES > 1) ? STAGES - 1 : 1;

  // Stage k carries the not-yet-compared upper digits, packed back to back.
  function automatic int data_off(input int k);
    return DIGIT * (k * (STAGES - 1) - (k * (k - 1)) / 2);
  endfunction

  function automatic logic [1:0] digit_cmp(input logic [DIGIT-1:0] da,
                                           input logic [DIGIT-1:0] db,
                                           input logic             flip);
    logic [DIGIT-1:0] xa;
    logic [DIGIT-1:0] xb;
    xa = da;
    xb = db;
    xa[DIGIT-1] = da[DIGIT-1] ^ flip;
    xb[DIGIT-1] = db[DIGIT-1] ^ flip;
    return {xa > xb, xa < xb};
  endfunction

  logic [PIPE_BITS-1:0] a_pipe;
  logic [PIPE_BITS-1:0] b_pipe;
  logic [2*STAGES-1:0]  gl_pipe;
  logic [STAGES-1:0]    vld_pipe;
  logic [SM_BITS-1:0]   sm_pipe;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM = WIDTH - (k + 1) * DIGIT;
    localparam bit TOP = (k == STAGES - 1);

    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;
    logic [1:0]       gl_in;
    logic             vld_in;
    logic             sm_in;
    logic [1:0]       cmp;
    logic [1:0]       gl_d;
    logic [1:0]       gl_q;
    logic             vld_d;
    logic             vld_q;

    if (k == 0) begin : g_first
      assign da     = a[DIGIT-1:0];
      assign db     = b[DIGIT-1:0];
      assign gl_in  = 2'b00;
      assign vld_in = in_valid;
      assign sm_in  = signed_mode;
    end else begin : g_next
      localparam int OFF = data_off(k - 1);
      assign da     = a_pipe[OFF +: DIGIT];
      assign db     = b_pipe[OFF +: DIGIT];
      assign gl_in  = gl_pipe[2*(k-1) +: 2];
      assign vld_in = vld_pipe[k-1];
      assign sm_in  = sm_pipe[k-1];
    end

    // Only the most significant digit sees the sign-bit inversion.
    assign cmp = digit_cmp(da, db, TOP && sm_in);

    always_comb begin
      gl_d  = gl_q;
      vld_d = vld_q;
      if (en) begin
        gl_d  = (cmp != 2'b00) ? cmp : gl_in;
        vld_d = vld_in;
      end
      if (flush) begin
        vld_d = 1'b0;
      end
    end

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        gl_q  <= 2'b00;
        vld_q <= 1'b0;
      end else begin
        gl_q  <= gl_d;
        vld_q <= vld_d;
      end
    end

    assign gl_pipe[2*k +: 2] = gl_q;
    assign vld_pipe[k]       = vld_q;

    if (!TOP) begin : g_carry
      logic [REM-1:0] a_rest;
      logic [REM-1:0] b_rest;
      logic [REM-1:0] a_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_d;
      logic [REM-1:0] b_q;
      logic           sm_d;
      logic           sm_q;

      if (k == 0) begin : g_src_in
        assign a_rest = a[WIDTH-1:DIGIT];
        assign b_rest = b[WIDTH-1:DIGIT];
      end else begin : g_src_pipe
        assign a_rest = a_pipe[data_off(k - 1) + DIGIT +: REM];
        assign b_rest = b_pipe[data_off(k - 1) + DIGIT +: REM];
      end

      always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        sm_d = sm_q;
        if (en) begin
          a_d  = a_rest;
          b_d  = b_rest;
          sm_d = sm_in;
        end
      end

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          a_q  <= '0;
          b_q  <= '0;
          sm_q <= 1'b0;
        end else begin
          a_q  <= a_d;
          b_q  <= b_d;
          sm_q <= sm_d;
        end
      end

      assign a_pipe[data_off(k) +: REM] = a_q;
      assign b_pipe[data_off(k) +: REM] = b_q;
      assign sm_pipe[k]                 = sm_q;
    end
  end

  logic [1:0] fin_gl;
  logic       fin_vld;
  logic       out_valid_d;
  logic       out_valid_q;
  logic       gt_d;
  logic       gt_q;
  logic       eq_d;
  logic       eq_q;
  logic       lt_d;
  logic       lt_q;

  assign fin_gl  = gl_pipe[2*(STAGES-1) +: 2];
  assign fin_vld = vld_pipe[STAGES-1];

  // A flushed sample never reaches the result flops.
  always_comb begin
    out_valid_d = out_valid_q;
    gt_d        = gt_q;
    eq_d        = eq_q;
    lt_d        = lt_q;
    if (en && !flush) begin
      out_valid_d = fin_vld;
      if (fin_vld) begin
        gt_d = fin_gl[1];
        lt_d = fin_gl[0];
        eq_d = ~fin_gl[1] & ~fin_gl[0];
      end
    end
    if (flush) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      gt_q        <= gt_d;
      eq_q        <= eq_d;
      lt_q        <= lt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign gt        = gt_q;
  assign eq        = eq_q;
  assign lt        = lt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_magnitude_compare.sv
// ---------------------------------------------------------------------------
// tb_pipelined_magnitude_compare
// Scoreboard bench for the pipelined magnitude comparator (defaults 16/2).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipelined_magnitude_compare;

  localparam int WIDTH   = 16;
  localparam int DIGIT   = 2;
  localparam int LATENCY = WIDTH / DIGIT;

  typedef struct {
    logic [2:0] res;
    int         stamp;
  } sb_entry_t;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             gt;
  logic             eq;
  logic             lt;

  pipelined_magnitude_compare #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .CLK         (clk),
    .RST         (rst_n),
    .en          (en),
    .flush       (flush),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         en_cnt  = 0;
  int         ev_cnt  = 0;
  logic       en_last = 1'b0;
  logic [2:0] last_res = 3'b000;
  sb_entry_t  sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                       input logic sm);
    logic g;
    logic l;
    if (sm) begin
      g = $signed(ma) > $signed(mb);
      l = $signed(ma) < $signed(mb);
    end else begin
      g = ma > mb;
      l = ma < mb;
    end
    return {g, (ma == mb), l};
  endfunction

  // Capture side: push expected result on each edge that accepts a sample.
  always @(posedge clk) begin
    if (!rst_n) begin
      en_last <= 1'b0;
    end else begin
      en_last <= en;
      if (flush) begin
        sb.delete();
      end
      if (en) begin
        en_cnt <= en_cnt + 1;
        if (in_valid && !flush) begin
          sb.push_back('{res: model(a, b, signed_mode), stamp: en_cnt + 1});
        end
      end
    end
  end

  // Result side: one new event per en-qualified edge with out_valid set.
  always @(negedge clk) begin
    sb_entry_t e;
    if (!rst_n) begin
      last_res = 3'b000;
    end else if (en_last) begin
      if (out_valid) begin
        ev_cnt++;
        if (sb.size() == 0) begin
          check_eq("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("result_gt_eq_lt", {29'd0, gt, eq, lt}, {29'd0, e.res});
          check_eq("latency", en_cnt - e.stamp, LATENCY);
          last_res = e.res;
        end
      end else begin
        check_eq("hold_gt_eq_lt", {29'd0, gt, eq, lt}, {29'd0, last_res});
      end
    end
  end

  task automatic drive(input logic v, input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                       input logic sm);
    in_valid    = v;
    a           = da;
    b           = db;
    signed_mode = sm;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    in_valid = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    @(negedge clk);
    check_eq("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev_before;
    rst_n = 1'b0;
    en = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset, then equal operands.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle_outputs", {28'd0, out_valid, gt, eq, lt}, 32'd0);
    end
    @(posedge clk);
    #1;
    drive(1'b1, 16'h1234, 16'h1234, 1'b0);
    drain(40);

    // Unsigned then signed on the same operands, back to back.
    drive(1'b1, 16'h8001, 16'h7FFF, 1'b0);
    drive(1'b1, 16'h8001, 16'h7FFF, 1'b1);
    drain(40);

    // LSB-only difference, higher digit override, signed -1 vs 0.
    drive(1'b1, 16'h0002, 16'h0001, 1'b0);
    drive(1'b1, 16'h0100, 16'h00FF, 1'b0);
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    drive(1'b1, 16'h0000, 16'hFFFF, 1'b0);
    drain(40);

    // Random stream with a 3-cycle stall.
    ev_before = ev_cnt;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        en = 1'b0;
        for (int j = 0; j < 3; j++) drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0);
        en = 1'b1;
      end
      drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    end
    drain(60);
    check_eq("stream_event_count", ev_cnt - ev_before, 16);

    // Bubble between two valid samples.
    drive(1'b1, 16'h0005, 16'h0003, 1'b0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    drive(1'b1, 16'h0010, 16'h0020, 1'b0);
    drain(40);

    // Flush kills three in-flight samples; the next one survives.
    ev_before = ev_cnt;
    drive(1'b1, 16'h1111, 16'h2222, 1'b0);
    drive(1'b1, 16'h3333, 16'h3333, 1'b0);
    drive(1'b1, 16'h9999, 16'h1111, 1'b1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    flush = 1'b1;
    drive(1'b1, 16'hAAAA, 16'h5555, 1'b0);
    flush = 1'b0;
    drive(1'b1, 16'h4000, 16'h4001, 1'b0);
    drain(40);
    check_eq("flush_event_count", ev_cnt - ev_before, 1);

    // Flush while stalled still clears the tags.
    ev_before = ev_cnt;
    drive(1'b1, 16'h0F00, 16'h00F0, 1'b0);
    drive(1'b1, 16'h00F0, 16'h0F00, 1'b0);
    en = 1'b0;
    flush = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    flush = 1'b0;
    @(negedge clk);
    check_eq("flush_en0_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    en = 1'b1;
    drain(40);
    check_eq("flush_en0_event_count", ev_cnt - ev_before, 0);

    // Asynchronous reset with samples in flight.
    for (int i = 0; i < 10; i++) drive(1'b1, 16'h7000 + 16'(i), 16'h0100, 1'b0);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    sb.delete();
    #1;
    check_eq("async_reset_outputs", {28'd0, out_valid, gt, eq, lt}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("post_reset_idle", {28'd0, out_valid, gt, eq, lt}, 32'd0);
    end
    @(posedge clk);
    #1;
    drive(1'b1, 16'h8000, 16'h0001, 1'b1);
    drain(40);

    check_eq("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
